prim_subreg_ext_hs: RTL
=======================

PRIM_SUBREG_EXT_HS -- requirements
Module: prim_subreg_ext_hs

Interface
REQ-001 SHALL have parameter DW, default 32: data width; legal values are multiples of 8, from 8 to 64.
REQ-002 SHALL have parameter TO_CYCLES, default 255: timeout limit in clk_i cycles; legal range 1..65535.
REQ-003 SHALL have ports:
- clk_i  in  1  clock; the block has one clock domain.
- rst_i  in  1  reset, asynchronous assert, active-high.
REQ-004 SHALL have register-side ports:
- re  in  1  read request.
- we  in  1  write request.
- wd  in  DW  write data.
- be  in  DW/8  byte enables.
- busy  out  1  access in flight.
- done  out  1  access-complete pulse.
- err  out  1  error flag, valid with done.
- qs  out  DW  read data.
REQ-005 SHALL have hardware-side ports:
- q  out  DW  shadow value.
- qe  out  1  write request, level.
- qre  out  1  read request, level.
- hw_ack  in  1  hardware acknowledge.
- d  in  DW  hardware read data.

Function
REQ-006 SHALL implement FSM states IDLE, WR_WAIT and RD_WAIT, encoded as an enum in the package.
REQ-007 SHALL, in IDLE with we=1, merge wd into the q shadow per enabled byte on that clock edge, then enter WR_WAIT.
REQ-008 SHALL, in IDLE with re=1 and we=0, enter RD_WAIT.
REQ-009 SHALL, in IDLE with we=1 and re=1 together, give priority to the write and drop the read; no error is raised.
REQ-010 SHALL, in IDLE with we=1 and be all zero, leave q unchanged and still run the WR_WAIT handshake.
REQ-011 SHALL drive qe=1 exactly while in WR_WAIT and qre=1 exactly while in RD_WAIT.
REQ-012 SHALL drive busy=1 in any state other than IDLE.
REQ-013 SHALL sample hw_ack only in WR_WAIT or RD_WAIT; hw_ack in IDLE is ignored.
REQ-014 SHALL, on hw_ack=1 in WR_WAIT, return to IDLE and pulse done=1 with err=0 for one cycle in the following cycle.
REQ-015 SHALL, on hw_ack=1 in RD_WAIT, capture d into qs, return to IDLE, and pulse done=1 with err=0 in the following cycle.
REQ-016 SHALL hold qs stable between reads.
REQ-017 SHALL ignore re and we while busy=1, with no state, q or qs change.
REQ-018 SHALL, as minimum latency, produce done 2 cycles after the request when hw_ack is returned on the first WAIT cycle.
REQ-019 SHALL accept a new request in the same cycle that done=1 is asserted.
REQ-020 SHALL keep err low whenever done is low.

Reset
REQ-021 SHALL, on rst_i=1, immediately set state=IDLE and clear q, qs, qe, qre, busy, done, err and the timeout counter.
REQ-022 SHALL abandon any access in flight when reset is asserted mid-access, with no done pulse.
REQ-023 SHALL release reset asynchronously and begin operating on the first clk_i edge after rst_i deasserts.

Configuration
REQ-024 SHALL use macro PRIM_SUBREG_EXT_HS_TIMEOUT_EN to compile the timeout in or out.
REQ-025 SHALL, when the macro is defined, count cycles spent in WR_WAIT or RD_WAIT with a 16-bit counter that is cleared on entry to either WAIT state.
REQ-026 SHALL, when the macro is defined and the count reaches TO_CYCLES without hw_ack, return to IDLE and pulse done=1 with err=1.
REQ-027 SHALL, when a timeout ends a read, load qs with all ones.
REQ-028 SHALL, when a timeout ends a write, leave q at its merged value.
REQ-029 SHALL give hw_ack priority when hw_ack arrives in the same cycle the count reaches TO_CYCLES (err=0).
REQ-030 SHALL, when the macro is undefined, wait for hw_ack indefinitely, hold err constant 0, and contain no counter logic.

Structure
REQ-031 SHALL place the state enum type (ext_hs_state_e) and the all-ones read-error constant in package prim_subreg_ext_pkg.
REQ-032 SHALL place the timeout counter in sub-module prim_subreg_ext_timer (ports: clk_i, rst_i, clr, en, limit, expired).
REQ-033 SHALL instantiate prim_subreg_ext_timer only under PRIM_SUBREG_EXT_HS_TIMEOUT_EN.

Verification
REQ-034 SHALL cover the write with byte enables: after reset, with DW=32, write wd=0xAABBCCDD, be=4'b0101, and hw_ack on the 3rd WAIT cycle -> q=0x00BB00DD, qe high for 3 cycles, then done=1, err=0.
REQ-035 SHALL cover the read: re=1, d=0x12345678, and hw_ack on the 1st WAIT cycle -> qs=0x12345678 and done 2 cycles after re.
REQ-036 SHALL cover the collision and busy cases: we=1 and re=1 together -> write only, qre never high; a second we while busy -> ignored, q unchanged.
REQ-037 SHALL cover the timeout, with the macro defined and TO_CYCLES=4: a read with no hw_ack -> done=1, err=1, qs=0xFFFFFFFF; hw_ack at count 4 -> err=0.
REQ-038 SHALL cover reset mid-access: rst_i asserted during WR_WAIT -> qe, busy and q are 0 with no clk_i edge needed, and no done pulse follows.
REQ-039 SHALL cover back-to-back access: a new we in the done cycle -> accepted, with busy rising again in the next cycle.

Source files
------------

// File: rtl/prim_subreg_ext_pkg.sv
// prim_subreg_ext_pkg: shared state encoding and read-error value for the external subreg handshake
package prim_subreg_ext_pkg;
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WR_WAIT = 2'd1,
        RD_WAIT = 2'd2
    } ext_hs_state_e;
    localparam logic [63:0] RD_ERR_VAL = '1;
endpackage

// File: rtl/prim_subreg_ext_timer.sv
// prim_subreg_ext_timer: 16-bit wait-cycle counter, expires on the cycle the count reaches limit
module prim_subreg_ext_timer (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        clr,
    input  logic        en,
    input  logic [15:0] limit,
    output logic        expired
);
    logic [15:0] cnt_q, cnt_d;
    always_comb cnt_d = clr ? 16'd0 : en ? cnt_q + 16'd1 : cnt_q;
    assign expired = en && (cnt_q + 16'd1 == limit);
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) cnt_q <= 16'd0;
        else       cnt_q <= cnt_d;
    end
endmodule

// File: rtl/prim_subreg_ext_hs.sv
// prim_subreg_ext_hs: handshaked external subreg; PRIM_SUBREG_EXT_HS_TIMEOUT_EN adds an access timeout
module prim_subreg_ext_hs
    import prim_subreg_ext_pkg::*;
#(
    parameter int DW        = 32,
    parameter int TO_CYCLES = 255
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            re,
    input  logic            we,
    input  logic [DW-1:0]   wd,
    input  logic [DW/8-1:0] be,
    output logic            busy,
    output logic            done,
    output logic            err,
    output logic [DW-1:0]   qs,
    output logic [DW-1:0]   q,
    output logic            qe,
    output logic            qre,
    input  logic            hw_ack,
    input  logic [DW-1:0]   d
);
    ext_hs_state_e state_q, state_d;
    logic [DW-1:0] q_q, q_d, qs_q, qs_d, wmask;
    logic done_q, done_d, err_q, err_d, to_exp;
`ifdef PRIM_SUBREG_EXT_HS_TIMEOUT_EN
    prim_subreg_ext_timer u_timer (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .clr     (state_q == IDLE),
        .en      (state_q != IDLE),
        .limit   (16'(TO_CYCLES)),
        .expired (to_exp)
    );
`else
    assign to_exp = 1'b0;
`endif
    always_comb begin
        wmask = '0;
        for (int i = 0; i < DW/8; i++) wmask[i*8 +: 8] = {8{be[i]}};
    end
    // hw_ack wins over a simultaneous timeout, so err only reports a genuine miss
    always_comb begin
        state_d = state_q;
        q_d     = q_q;
        qs_d    = qs_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        if (state_q == IDLE) begin
            if (we) begin
                q_d     = (q_q & ~wmask) | (wd & wmask);
                state_d = WR_WAIT;
            end else if (re) begin
                state_d = RD_WAIT;
            end
        end else if (hw_ack || to_exp) begin
            state_d = IDLE;
            done_d  = 1'b1;
            err_d   = !hw_ack;
            qs_d    = (state_q == RD_WAIT) ? (hw_ack ? d : RD_ERR_VAL[DW-1:0]) : qs_q;
        end
    end
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            q_q     <= '0;
            qs_q    <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            q_q     <= q_d;
            qs_q    <= qs_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end
    assign busy = state_q != IDLE;
    assign qe   = state_q == WR_WAIT;
    assign qre  = state_q == RD_WAIT;
    assign done = done_q;
    assign err  = err_q;
    assign q    = q_q;
    assign qs   = qs_q;
endmodule
